host_debug_port: RTL and testbench

- Byte-stream host access port for nand_cpu. Hardware counterpart to the bench-side host role.
- Accepts commands from an external host over a valid/ready byte channel and returns one response byte per command on a second channel.
- Commands write and read data-memory bytes, and run the CPU from reset to halt.
- Sits between the host link and the nand_cpu data-memory port. Owns the CPU reset line.

---
 rtl/host_debug_pkg.sv | 13 +
 rtl/host_debug_port_if.sv | 23 ++
 rtl/host_debug_port_run_watchdog.sv | 32 +++
 rtl/host_debug_port.sv | 69 ++++++
 tb/tb_host_debug_port.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/host_debug_pkg.sv
// host_debug_pkg: shared state encoding, opcodes and response codes for host_debug_port
package host_debug_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_GET_ADDR, S_GET_DATA, S_MEM_WR, S_MEM_RD,
      S_RD_WAIT, S_RST_PULSE, S_RELEASE, S_RUN, S_RESP
   } state_t;
   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_READ = 8'h02;
   localparam logic [7:0] OP_RUN = 8'h03;
   localparam logic [7:0] RSP_OK = 8'h00;
   localparam logic [7:0] RSP_TIMEOUT = 8'hFF;
   localparam logic [7:0] RSP_BADOP = 8'hEE;
endpackage

// File: rtl/host_debug_port_if.sv
// host_debug_port_if: host byte channels, data-memory port and CPU control lines
interface host_debug_port_if #(parameter int DMEM_AW = 8) ();
   logic cmd_valid;
   logic cmd_ready;
   logic [7:0] cmd_data;
   logic rsp_valid;
   logic rsp_ready;
   logic [7:0] rsp_data;
   logic mem_we;
   logic [DMEM_AW-1:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic cpu_n_rst;
   logic cpu_halt;
   modport slave (
      input cmd_valid, cmd_data, rsp_ready, mem_rdata, cpu_halt,
      output cmd_ready, rsp_valid, rsp_data, mem_we, mem_addr, mem_wdata, cpu_n_rst
   );
   modport master (
      output cmd_valid, cmd_data, rsp_ready, mem_rdata, cpu_halt,
      input cmd_ready, rsp_valid, rsp_data, mem_we, mem_addr, mem_wdata, cpu_n_rst
   );
endinterface

// File: rtl/host_debug_port_run_watchdog.sv
// run_watchdog: reset pulse timing, run timeout counter and halt/timeout arbitration
module run_watchdog
   import host_debug_pkg::*;
#(
   parameter int RUN_TIMEOUT = 65535,
   parameter int RST_CYCLES = 2
) (
   input logic clk,
   input logic rst,
   input state_t state,
   input logic cpu_halt,
   output logic pulse_done,
   output logic run_done,
   output logic [7:0] run_code,
   output logic cpu_n_rst
);
   localparam int CW = $clog2((RUN_TIMEOUT > RST_CYCLES ? RUN_TIMEOUT : RST_CYCLES) + 1);
   logic [CW-1:0] cnt;
   logic in_pulse, in_run, halted, timeout;
   assign in_pulse = state == S_RST_PULSE;
   assign in_run = state == S_RUN;
   // halt is only trusted in RUN; during RELEASE it may be left over from the last run
   assign halted = in_run && cpu_halt;
   assign timeout = in_run && cnt == CW'(RUN_TIMEOUT - 1);
   assign pulse_done = in_pulse && cnt == CW'(RST_CYCLES - 1);
   assign run_done = halted || timeout;
   assign run_code = halted ? RSP_OK : RSP_TIMEOUT;
   assign cpu_n_rst = state == S_RELEASE || in_run;
   always_ff @(posedge clk)
      if (rst || pulse_done || run_done || !(in_pulse || in_run)) cnt <= '0;
      else cnt <= cnt + 1'b1;
endmodule

// File: rtl/host_debug_port.sv
// host_debug_port: byte-command host port for memory access and CPU run control
module host_debug_port
   import host_debug_pkg::*;
#(
   parameter int DMEM_AW = 8,
   parameter int RUN_TIMEOUT = 65535,
   parameter int RST_CYCLES = 2
) (
   input logic clk,
   input logic rst,
   host_debug_port_if.slave bus,
   output logic busy
);
   state_t state, next;
   logic [7:0] op, wdata, rsp;
   logic [DMEM_AW-1:0] addr;
   logic cmd_hs, rsp_hs, mem_op, pulse_done, run_done;
   logic [7:0] run_code;
   run_watchdog #(.RUN_TIMEOUT(RUN_TIMEOUT), .RST_CYCLES(RST_CYCLES)) wd (
      .clk(clk), .rst(rst), .state(state), .cpu_halt(bus.cpu_halt),
      .pulse_done(pulse_done), .run_done(run_done), .run_code(run_code),
      .cpu_n_rst(bus.cpu_n_rst)
   );
   assign bus.cmd_ready = !rst && (state == S_IDLE || state == S_GET_ADDR || state == S_GET_DATA);
   assign cmd_hs = bus.cmd_valid && bus.cmd_ready;
   assign rsp_hs = bus.rsp_valid && bus.rsp_ready;
   assign mem_op = bus.cmd_data == OP_WRITE || bus.cmd_data == OP_READ;
   assign bus.rsp_valid = state == S_RESP;
   assign bus.rsp_data = rsp;
   assign bus.mem_we = state == S_MEM_WR;
   // the memory port belongs to the CPU whenever it is out of reset
   assign bus.mem_addr = bus.cpu_n_rst ? '0 : addr;
   assign bus.mem_wdata = bus.cpu_n_rst ? '0 : wdata;
   assign busy = state != S_IDLE;
   always_comb begin
      next = state;
      case (state)
         S_IDLE: if (cmd_hs) next = mem_op ? S_GET_ADDR : bus.cmd_data == OP_RUN ? S_RST_PULSE : S_RESP;
         S_GET_ADDR: if (cmd_hs) next = op == OP_WRITE ? S_GET_DATA : S_MEM_RD;
         S_GET_DATA: if (cmd_hs) next = S_MEM_WR;
         S_MEM_WR: next = S_RESP;
         S_MEM_RD: next = S_RD_WAIT;
         S_RD_WAIT: next = S_RESP;
         S_RST_PULSE: if (pulse_done) next = S_RELEASE;
         S_RELEASE: next = S_RUN;
         S_RUN: if (run_done) next = S_RESP;
         S_RESP: if (rsp_hs) next = S_IDLE;
         default: next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) state <= S_IDLE;
      else state <= next;
   always_ff @(posedge clk)
      if (rst) begin
         op <= '0;
         addr <= '0;
         wdata <= '0;
         rsp <= '0;
      end else begin
         if (state == S_IDLE && cmd_hs) op <= bus.cmd_data;
         if (state == S_IDLE && cmd_hs && !mem_op && bus.cmd_data != OP_RUN) rsp <= RSP_BADOP;
         if (state == S_GET_ADDR && cmd_hs) addr <= bus.cmd_data[DMEM_AW-1:0];
         if (state == S_GET_DATA && cmd_hs) wdata <= bus.cmd_data;
         if (state == S_MEM_WR) rsp <= RSP_OK;
         if (state == S_RD_WAIT) rsp <= bus.mem_rdata;
         if (state == S_RUN && run_done) rsp <= run_code;
      end
endmodule

// File: tb/tb_host_debug_port.sv
// tb_host_debug_port: directed and random host commands against a memory/CPU model and scoreboard
module tb_host_debug_port;
   import host_debug_pkg::*;
   localparam int TO = 16;
   logic clk = 0;
   logic rst = 1;
   logic busy;
   logic init_mem = 1;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   host_debug_port_if #(.DMEM_AW(8)) bus ();
   host_debug_port #(.DMEM_AW(8), .RUN_TIMEOUT(TO), .RST_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave), .busy(busy)
   );
   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   int halt_after = 0;
   int run_cnt = 0;
   logic halt_r = 0;
   assign bus.cpu_halt = halt_r;
   // memory with one-cycle read latency plus a CPU that runs a signed 16-bit less-than program
   always @(posedge clk) begin
      if (init_mem) for (int k = 0; k < 256; k++) mem[k] <= 8'(k * 37 + 11);
      bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.cpu_n_rst) begin
         run_cnt <= run_cnt + 1;
         if (halt_after != 0 && run_cnt + 1 >= halt_after) begin
            halt_r <= 1;
            mem[4] <= ($signed({mem[1], mem[0]}) < $signed({mem[3], mem[2]})) ? 8'h01 : 8'h00;
         end else halt_r <= 0;
      end else run_cnt <= 0;
   end
   int we_cnt = 0, we_bad = 0, rsp_cnt = 0, nrst_hi = 0;
   logic [7:0] we_addr = 0, we_data = 0;
   always @(posedge clk) begin
      if (bus.mem_we) begin
         we_cnt <= we_cnt + 1;
         we_addr <= bus.mem_addr;
         we_data <= bus.mem_wdata;
         if (bus.cpu_n_rst) we_bad <= we_bad + 1;
      end
      if (bus.rsp_valid && bus.rsp_ready) rsp_cnt <= rsp_cnt + 1;
      if (bus.cpu_n_rst) nrst_hi <= nrst_hi + 1;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [7:0] b);
      int n = 0;
      bus.cmd_valid = 1;
      bus.cmd_data = b;
      while (!bus.cmd_ready && n < 60) begin
         step();
         n++;
      end
      chk("cmd_accept", bus.cmd_ready, 1);
      step();
      bus.cmd_valid = 0;
   endtask
   task automatic wait_rsp(input int bound, output int lat);
      lat = 1;
      while (!bus.rsp_valid && lat < bound) begin
         step();
         lat++;
      end
      chk("rsp_arrives", bus.rsp_valid, 1);
   endtask
   task automatic take_rsp(output logic [7:0] d);
      d = bus.rsp_data;
      bus.rsp_ready = 1;
      step();
      bus.rsp_ready = 0;
      chk("rsp_drops", bus.rsp_valid, 0);
      chk("ready_after_rsp", bus.cmd_ready, 1);
   endtask
   function automatic logic [7:0] lt_ref();
      return ($signed({ref_mem[1], ref_mem[0]}) < $signed({ref_mem[3], ref_mem[2]})) ? 8'h01 : 8'h00;
   endfunction
   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      int lat, w0;
      logic [7:0] r;
      w0 = we_cnt;
      send(OP_WRITE);
      send(a);
      send(d);
      wait_rsp(20, lat);
      chk("wr_latency", lat, 2);
      take_rsp(r);
      chk("wr_rsp", r, RSP_OK);
      chk("wr_pulses", we_cnt - w0, 1);
      chk("wr_addr", we_addr, a);
      chk("wr_data", we_data, d);
      ref_mem[a] = d;
   endtask
   task automatic do_read(input logic [7:0] a);
      int lat;
      logic [7:0] r;
      send(OP_READ);
      send(a);
      wait_rsp(20, lat);
      chk("rd_latency", lat, 3);
      take_rsp(r);
      chk("rd_data", r, ref_mem[a]);
   endtask
   task automatic do_badop(input logic [7:0] b);
      int lat, w0, h0;
      logic [7:0] r;
      w0 = we_cnt;
      h0 = nrst_hi;
      send(b);
      wait_rsp(20, lat);
      chk("bad_latency", lat, 1);
      take_rsp(r);
      chk("bad_rsp", r, RSP_BADOP);
      chk("bad_no_we", we_cnt - w0, 0);
      chk("bad_no_run", nrst_hi - h0, 0);
   endtask
   task automatic do_run(input int ha);
      int lat, h0;
      logic [7:0] r;
      logic halts;
      halts = ha != 0 && ha <= TO;
      halt_after = ha;
      h0 = nrst_hi;
      send(OP_RUN);
      wait_rsp(TO + 40, lat);
      chk("run_nrst_low", bus.cpu_n_rst, 0);
      chk("run_cycles", nrst_hi - h0, halts ? ha + 1 : TO + 1);
      take_rsp(r);
      chk("run_rsp", r, halts ? RSP_OK : RSP_TIMEOUT);
      if (halts) ref_mem[4] = lt_ref();
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_cmd_ready"}, bus.cmd_ready, 0);
      chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
      chk({tag, "_rsp_data"}, bus.rsp_data, 0);
      chk({tag, "_mem_we"}, bus.mem_we, 0);
      chk({tag, "_mem_addr"}, bus.mem_addr, 0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
      chk({tag, "_cpu_n_rst"}, bus.cpu_n_rst, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask
   initial begin
      #500000;
      $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end
   initial begin
      int n, r0;
      logic [7:0] b, a, r;
      bus.cmd_valid = 0;
      bus.cmd_data = 0;
      bus.rsp_ready = 0;
      for (int k = 0; k < 256; k++) ref_mem[k] = 8'(k * 37 + 11);
      step();
      step();
      chk_reset("reset");
      init_mem = 0;
      rst = 0;
      step();
      chk("idle_ready", bus.cmd_ready, 1);
      do_write(8'h00, 8'h34);
      do_read(8'h00);
      do_write(8'h00, 8'h00);
      do_write(8'h01, 8'h80);
      do_write(8'h02, 8'h01);
      do_write(8'h03, 8'h00);
      do_run(7);
      do_read(8'h04);
      chk("lt_result", ref_mem[4], 8'h01);
      do_run(0);
      do_run(3);
      do_run(5);
      do_run(TO);
      do_run(TO + 1);
      do_badop(8'h7A);
      do_read(8'h02);
      send(OP_READ);
      send(8'h01);
      wait_rsp(20, n);
      for (int i = 0; i < 10; i++) begin
         chk("stall_valid", bus.rsp_valid, 1);
         chk("stall_data", bus.rsp_data, ref_mem[1]);
         chk("stall_ready", bus.cmd_ready, 0);
         step();
      end
      r0 = rsp_cnt;
      take_rsp(r);
      chk("stall_rsp", r, ref_mem[1]);
      chk("stall_one_rsp", rsp_cnt - r0, 1);
      r0 = rsp_cnt;
      halt_after = 0;
      send(OP_RUN);
      n = 0;
      while (!bus.cpu_n_rst && n < 20) begin
         step();
         n++;
      end
      chk("abort_released", bus.cpu_n_rst, 1);
      repeat (5) step();
      rst = 1;
      step();
      chk_reset("abort");
      step();
      rst = 0;
      repeat (TO + 5) step();
      chk("abort_no_rsp", rsp_cnt - r0, 0);
      chk("abort_idle", busy, 0);
      chk("abort_nrst", bus.cpu_n_rst, 0);
      do_read(8'h04);
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: do_write(8'($urandom), 8'($urandom));
            4, 5, 6: do_read(8'($urandom));
            7: begin
               b = 8'($urandom);
               while (b == OP_WRITE || b == OP_READ || b == OP_RUN) b = 8'($urandom);
               do_badop(b);
            end
            default: do_run(int'($urandom_range(0, 20)));
         endcase
      end
      for (int k = 0; k < 6; k++) begin
         a = 8'(k);
         do_read(a);
      end
      chk("we_only_in_reset", we_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
